// File: rtl/mult_seq_32bit.sv
// mult_seq_32bit
//   Multi-cycle unsigned shift-add multiplier. This block drives the MULT
//   operand of the ALU result mux. It retires one multiplier bit per clock.
//   The CPU control unit stalls while busy is high. It then reads
//   result_lo/result_hi.
//
// Parameters
//   WIDTH  operand width; the product is 2*WIDTH bits
//   CNT_W  iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous, active-high; forces IDLE and clears outputs
//   start      in   operation request, accepted only in IDLE
//   value1     in   multiplicand, captured when start is accepted
//   value2     in   multiplier, captured when start is accepted
//   busy       out  high while iterating (RUN)
//   done       out  one-cycle pulse when result_hi/result_lo hold a new product
//   result_lo  out  low half of the product
//   result_hi  out  high half of the product
//
// Optional build macro
//   MULT_ZERO_BYPASS_EN  a zero operand skips RUN and completes in one cycle

module mult_seq_32bit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value1,
  input  logic [WIDTH-1:0] value2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo_nxt;
  logic             zero_op;

`ifdef MULT_ZERO_BYPASS_EN
  assign zero_op = (value1 == '0) || (value2 == '0);
`else
  assign zero_op = 1'b0;
`endif

  // One shift-add step. The carry out of sum shifts into the top of acc_hi.
  // Bit 0 of sum shifts into the top of acc_lo, which is how the product
  // stays exact over 2*WIDTH bits.
  always_comb begin
    sum        = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    acc_hi_nxt = sum[WIDTH:1];
    acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
  end

  // ---- control: state register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = zero_op ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // ---- datapath: operand capture, iteration, result latch ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mcand     <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      cnt       <= '0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= value1;
            acc_hi <= '0;
            acc_lo <= value2;
            cnt    <= CNT_INIT;
            if (zero_op) begin
              result_hi <= '0;
              result_lo <= '0;
            end
          end
        end
        RUN: begin
          acc_hi <= acc_hi_nxt;
          acc_lo <= acc_lo_nxt;
          cnt    <= cnt - 1'b1;
          // The result registers load on the final step, so they change
          // exactly when the sequencer enters DONE.
          if (cnt == '0) begin
            result_hi <= acc_hi_nxt;
            result_lo <= acc_lo_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_32bit.sv
module tb_mult_seq_32bit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] value1 = '0;
  logic [31:0] value2 = '0;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [63:0] sb_q[$];

  mult_seq_32bit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .value1    (value1),
    .value2    (value2),
    .busy      (busy),
    .done      (done),
    .result_lo (result_lo),
    .result_hi (result_hi)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZERO_BUSY = 0;
  localparam int ZERO_LAT  = 1;
`else
  localparam int ZERO_BUSY = 32;
  localparam int ZERO_LAT  = 33;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE. Drives one operation and
  // watches it to completion. inj>0 raises start with 9x9 at that RUN
  // negedge, which must be ignored.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input int inj, input int exp_busy, input int exp_lat);
    int n;
    int bc;
    int lat;
    int ovl;
    logic [63:0] exp;
    logic [63:0] got;
    bc  = 0;
    lat = 0;
    ovl = 0;
    sb_q.push_back({32'd0, a} * {32'd0, b});
    start  = 1'b1;
    value1 = a;
    value2 = b;
    @(negedge clock);
    n = cyc;
    start = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (k > 0) @(negedge clock);
      if (busy && done) ovl++;
      if (done) begin
        lat = cyc + 1 - n;
        break;
      end
      if (busy) bc++;
      start = (inj > 0) && (k == inj);
      if ((inj > 0) && (k == inj)) begin
        value1 = 32'd9;
        value2 = 32'd9;
      end
    end
    start = 1'b0;
    exp = sb_q.pop_front();
    got = {result_hi, result_lo};
    chk({tag, "_lo"}, {32'd0, got[31:0]}, {32'd0, exp[31:0]});
    chk({tag, "_hi"}, {32'd0, got[63:32]}, {32'd0, exp[63:32]});
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
    chk({tag, "_done_latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_busy_done_overlap"}, 64'(ovl), 64'd0);
    @(negedge clock);
    chk({tag, "_done_pulse_1cyc"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    chk({tag, "_held"}, {result_hi, result_lo}, exp);
  endtask

  // Starts a x b and hits reset asynchronously at RUN negedge rst_k.
  task automatic run_abort(input logic [31:0] a, input logic [31:0] b, input int rst_k);
    int seen;
    seen = 0;
    start  = 1'b1;
    value1 = a;
    value2 = b;
    @(negedge clock);
    start = 1'b0;
    for (int k = 1; k <= rst_k; k++) @(negedge clock);
    chk("abort_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("abort_async_busy", {63'd0, busy}, 64'd0);
    chk("abort_async_done", {63'd0, done}, 64'd0);
    chk("abort_async_result", {result_hi, result_lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    chk("abort_no_done", 64'(seen), 64'd0);
    chk("abort_result_zero", {result_hi, result_lo}, 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_lo", {32'd0, result_lo}, 64'd0);
    chk("rst_hi", {32'd0, result_hi}, 64'd0);
    @(negedge clock);

    run_op("basic_7x6", 32'd7, 32'd6, 0, 32, 33);
    run_op("full_range", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 32, 33);
    chk("full_range_hi_const", {32'd0, result_hi}, 64'h0000_0000_FFFF_FFFE);
    // The next start is driven immediately after done, so this is back to back.
    run_op("ignored_start", 32'd3, 32'd5, 10, 32, 33);
    chk("ignored_start_15", {32'd0, result_lo}, 64'd15);

    repeat (3) @(negedge clock);
    chk("idle_hold_lo", {32'd0, result_lo}, 64'd15);

    run_abort(32'd100, 32'd200, 12);
    run_op("after_abort", 32'd100, 32'd200, 0, 32, 33);
    chk("after_abort_20000", {32'd0, result_lo}, 64'd20000);

    run_op("zero_operand", 32'd0, 32'h1234_5678, 0, ZERO_BUSY, ZERO_LAT);
    run_op("mixed", 32'hDEAD_BEEF, 32'h0000_1234, 0, 32, 33);
    run_op("zero_rhs", 32'h8000_0001, 32'd0, 0, ZERO_BUSY, ZERO_LAT);
    run_op("msb_only", 32'h8000_0000, 32'h8000_0000, 0, 32, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_seq_32bit.md
Name: mult_seq_32bit

Overview:
- Multi-cycle unsigned shift-add multiplier sequencer.
- Produces the MULT operand that feeds the ALU's 8:1 result mux (select 3'b111), which is currently undriven.
- Owns the start/busy/done handshake, an iteration counter and the partial-product registers.
- The CPU control unit stalls on busy and reads result_lo (and result_hi for a 64-bit product).

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE.
- start  input  1  request; sampled on a rising clock edge.
- value1  input  WIDTH  multiplicand; captured on an accepted start.
- value2  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the product becomes valid.
- result_lo  output  WIDTH  low half of the product.
- result_hi  output  WIDTH  high half of the product.

Behaviour:
- Interface: one clock (clock); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, busy=0, done=0, result_lo=0, result_hi=0, counter=0, all internal registers 0.
- State IDLE: start=1 captures mcand<=value1, acc_hi<=0, acc_lo<=value2, cnt<=WIDTH-1; goes to RUN. start=0 holds.
- State RUN, each cycle:
  - sum = {1'b0, acc_hi} + (acc_lo[0] ? mcand : 0), WIDTH+1 bits.
  - Shift right one: {acc_hi, acc_lo} <= {sum, acc_lo} >> 1.
  - cnt decrements by 1.
  - When cnt==0, this cycle is the last iteration; next state is DONE.
- State DONE, lasts one cycle:
  - done=1, busy=0; result_hi/result_lo show {acc_hi, acc_lo}.
  - Returns to IDLE.
- Latency: start sampled at edge N → busy from N+1 through N+WIDTH (WIDTH cycles) → done high at N+WIDTH+1.
- Outputs hold the last product in IDLE until the next completed operation.
  - result_* are not cleared at start.
  - result_* update only on entry to DONE.
- start while in RUN is ignored: no restart, no queueing, operands are not re-captured.
- start while in DONE is ignored. Start is accepted only in IDLE, so the earliest back-to-back start is sampled the cycle after done.
- Operand changes after acceptance have no effect.
- Arithmetic: unsigned only. The product is exact over 2*WIDTH bits with no overflow. The carry out of sum is kept through the shift.
- Reset mid-RUN: immediate return to IDLE. Outputs go to 0. No done pulse for the aborted operation.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro: MULT_ZERO_BYPASS_EN.
- Defined:
  - If value1==0 or value2==0 when start is accepted in IDLE, the next state is DONE directly; RUN is skipped and busy stays 0.
  - result_lo=0 and result_hi=0, with done at N+1.
  - Nonzero operands behave as normal.
- Undefined: every operation takes the full WIDTH cycles, including zero operands.

Test Plan:
- Reset: hold reset 3 cycles, release → busy=0, done=0, result_lo=0, result_hi=0. Assert reset asynchronously mid-cycle → outputs clear before the next edge.
- Basic: value1=7, value2=6, start 1 cycle → busy for exactly 32 cycles, done pulse at N+33, result_lo=42, result_hi=0.
- Full range: value1=value2=32'hFFFFFFFF → result_hi=32'hFFFFFFFE, result_lo=32'h00000001.
- Ignored start: start 3+5, then at cycle 10 of RUN apply start with 9×9 → result_lo=15 at the original done time, no second busy period.
- Reset mid-RUN: start 100×200, assert reset at RUN cycle 12 → IDLE, no done pulse, result=0. A fresh start 100×200 then yields result_lo=20000.
- Zero operand: value1=0, value2=32'h12345678.
  - With MULT_ZERO_BYPASS_EN: done at N+1, busy never high.
  - Without the macro: done at N+33.
  - In both cases result_lo=0 and result_hi=0.
